key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 15 +
 rtl/key_db_cell.sv | 110 +++++++++++
 rtl/key_debounce.sv | 33 +++
 tb/tb_key_debounce.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and timing defaults for the key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    PRESS_CHK   = 2'b01,
    PRESSED     = 2'b10,
    RELEASE_CHK = 2'b11
  } key_state_e;

  localparam int CLK_HZ                  = 80_000_000;
  localparam int DEBOUNCE_MS_DEFAULT     = 20;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

endpackage

// File: rtl/key_db_cell.sv
// One key channel: pad synchroniser, stability counter and press/release FSM.
// KEY_DEBOUNCE_SYNC3_EN deepens the synchroniser from 2 to 3 flops.
module key_db_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

`ifdef KEY_DEBOUNCE_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_N-1:0] sync_q, sync_d;
  key_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              s;

  assign sync_d = {sync_q[SYNC_N-2:0], key_raw};
  assign s      = sync_q[SYNC_N-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: N_KEYS independent cells plus an any-key-held flag.
// KEY_DEBOUNCE_SYNC3_EN (in key_db_cell) adds one synchroniser stage per key.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_any
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_db_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .clr        (clr),
      .key_raw    (key_raw[k]),
      .key_level  (key_level[k]),
      .key_press  (key_press[k]),
      .key_release(key_release[k])
    );
  end

  assign key_any = |key_level;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4; latency follows KEY_DEBOUNCE_SYNC3_EN.
module tb_key_debounce;

  localparam int N = 4;
  localparam int D = 4;
`ifdef KEY_DEBOUNCE_SYNC3_EN
  localparam int LAT = D + 4;
`else
  localparam int LAT = D + 3;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         key_any;

  int tests = 0;
  int fails = 0;

  key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .clr        (clr),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_any    (key_any)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    clr     = 1'b1;
    key_raw = '0;
    tick(2);
    tests++;
    if ({key_level, key_press, key_release, key_any} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b any=%b, want all 0",
               key_level, key_press, key_release, key_any);
    end
    clr = 1'b0;
    tick(2);
    tests++;
    if ({key_level, key_press, key_release, key_any} !== 13'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got lvl=%b prs=%b rel=%b any=%b, want all 0",
               key_level, key_press, key_release, key_any);
    end
  endtask

  task automatic test_clean_press();
    logic early = 1'b0;
    key_raw[0] = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (key_level !== 4'b0000 || key_press !== 4'b0000) early = 1'b1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL press_too_early: level/press rose before edge %0d", LAT);
    end
    tick();
    tests++;
    if (key_level !== 4'b0001 || key_press !== 4'b0001 || key_any !== 1'b1) begin
      fails++;
      $display("FAIL press_accept: got lvl=%b prs=%b any=%b, want 0001 0001 1",
               key_level, key_press, key_any);
    end
    tick();
    tests++;
    if (key_level !== 4'b0001 || key_press !== 4'b0000) begin
      fails++;
      $display("FAIL press_one_cycle: got lvl=%b prs=%b, want 0001 0000", key_level, key_press);
    end
    key_raw[0] = 1'b0;
    tick(LAT);
    tests++;
    if (key_level !== 4'b0000 || key_release !== 4'b0001 || key_any !== 1'b0) begin
      fails++;
      $display("FAIL clean_release: got lvl=%b rel=%b any=%b, want 0000 0001 0",
               key_level, key_release, key_any);
    end
    tick();
    tests++;
    if (key_release !== 4'b0000) begin
      fails++;
      $display("FAIL release_one_cycle: got rel=%b, want 0000", key_release);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat = 6'b011011;
    logic       seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_raw[1] = pat[i % 6];
      tick();
      if (key_level[1] !== 1'b0 || key_press[1] !== 1'b0 || key_release[1] !== 1'b0) seen = 1'b1;
    end
    key_raw[1] = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (key_level[1] !== 1'b0 || key_press[1] !== 1'b0 || key_release[1] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL bounce_reject: key 1 level or pulse seen, want none");
    end
  endtask

  task automatic test_release_bounce();
    logic seen = 1'b0;
    key_raw[0] = 1'b1;
    tick(LAT + 1);
    tests++;
    if (key_level !== 4'b0001) begin
      fails++;
      $display("FAIL rb_hold: got lvl=%b, want 0001", key_level);
    end
    key_raw[0] = 1'b0; tick(); if (key_press !== 0 || key_release !== 0) seen = 1'b1;
    tick();            if (key_press !== 0 || key_release !== 0) seen = 1'b1;
    key_raw[0] = 1'b1; tick(); if (key_press !== 0 || key_release !== 0) seen = 1'b1;
    key_raw[0] = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (key_press !== 0 || key_release !== 0 || key_level !== 4'b0001) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rb_no_early_pulse: pulse or level change before final release edge");
    end
    tick();
    tests++;
    if (key_release !== 4'b0001 || key_level !== 4'b0000 || key_press !== 4'b0000) begin
      fails++;
      $display("FAIL rb_release: got rel=%b lvl=%b prs=%b, want 0001 0000 0000",
               key_release, key_level, key_press);
    end
    tick(3);
    tests++;
    if (key_release !== 4'b0000 || key_press !== 4'b0000) begin
      fails++;
      $display("FAIL rb_quiet_after: got rel=%b prs=%b, want 0000 0000", key_release, key_press);
    end
  endtask

  task automatic test_simultaneous();
    key_raw = 4'b1001;
    tick(LAT);
    tests++;
    if (key_press !== 4'b1001 || key_level !== 4'b1001) begin
      fails++;
      $display("FAIL sim_press: got prs=%b lvl=%b, want 1001 1001", key_press, key_level);
    end
    tick();
    key_raw[0] = 1'b0;
    tick(LAT);
    tests++;
    if (key_release !== 4'b0001 || key_any !== 1'b1 || key_level !== 4'b1000) begin
      fails++;
      $display("FAIL sim_first_release: got rel=%b any=%b lvl=%b, want 0001 1 1000",
               key_release, key_any, key_level);
    end
    tick();
    key_raw[3] = 1'b0;
    tick(LAT - 1);
    tests++;
    if (key_any !== 1'b1) begin
      fails++;
      $display("FAIL sim_any_held: got any=%b, want 1", key_any);
    end
    tick();
    tests++;
    if (key_release !== 4'b1000 || key_any !== 1'b0) begin
      fails++;
      $display("FAIL sim_last_release: got rel=%b any=%b, want 1000 0", key_release, key_any);
    end
    tick(2);
  endtask

  task automatic test_reset_mid_hold();
    logic seen = 1'b0;
    key_raw[2] = 1'b1;
    tick(LAT + 1);
    tests++;
    if (key_level !== 4'b0100) begin
      fails++;
      $display("FAIL rst_hold: got lvl=%b, want 0100", key_level);
    end
    clr = 1'b1;
    #1;
    tests++;
    if (key_level !== 4'b0000 || key_any !== 1'b0 || key_release !== 4'b0000) begin
      fails++;
      $display("FAIL rst_async_drop: got lvl=%b any=%b rel=%b, want 0000 0 0000",
               key_level, key_any, key_release);
    end
    tick(); if (key_release !== 0 || key_level !== 0) seen = 1'b1;
    tick(); if (key_release !== 0 || key_level !== 0) seen = 1'b1;
    clr = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (key_release !== 0 || key_press !== 0 || key_level !== 0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_quiet: pulse or level seen during/after clr before requalify");
    end
    tick();
    tests++;
    if (key_press !== 4'b0100 || key_level !== 4'b0100) begin
      fails++;
      $display("FAIL rst_requalify: got prs=%b lvl=%b, want 0100 0100", key_press, key_level);
    end
    key_raw[2] = 1'b0;
    tick(LAT + 2);
  endtask

  initial begin
    clr     = 1'b1;
    key_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
